// File: rtl/imem_if.sv
// ============================================================================
//  Module   : imem_if
//  Purpose  : Instruction-memory bus. It has a valid/ready address channel and
//             a separate response channel with no back-pressure.
//  Signals  : valid  - address request valid (fetch -> memory)
//             addr   - fetch address           (fetch -> memory)
//             ready  - memory accepts request  (memory -> fetch)
//             rvalid - response valid          (memory -> fetch)
//             rdata  - response instruction    (memory -> fetch)
//  Modports : master (fetch stage), slave (instruction memory)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_if #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
);
  logic              valid;
  logic [PC_W-1:0]   addr;
  logic              ready;
  logic              rvalid;
  logic [INST_W-1:0] rdata;

  modport master (output valid, output addr, input  ready, input  rvalid, input  rdata);
  modport slave  (input  valid, input  addr, output ready, output rvalid, output rdata);
endinterface

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
//  Module   : inst_fetch
//  Purpose  : RISC-V instruction-fetch stage. It holds the PC and issues
//             single-outstanding fetches over imem_if. It loads the IF/ID
//             register and accepts branch redirects from EX/MEM. A redirect
//             discards any stale fetch, whether in flight or buffered.
//  Ports    : i_clk, i_rst_n         - clock, async active-low reset
//             i_pcsrc,i_branch_target- redirect request and target PC
//             i_stall                - hold IF/ID and PC
//             imem (master)          - instruction-memory bus
//             o_if_id_valid/pc/inst  - IF/ID pipeline register
//             o_fetch_cnt            - delivered-instruction counter
//  Options  : define IF_PERF_CNT_EN to build the delivered-instruction
//             counter. When it is not defined, o_fetch_cnt is constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch #(
  parameter int              PC_W     = 64,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst_n,
  input  wire logic              i_pcsrc,
  input  wire logic [PC_W-1:0]   i_branch_target,
  input  wire logic              i_stall,
  imem_if.master                 imem,
  output logic                   o_if_id_valid,
  output logic [PC_W-1:0]        o_if_id_pc,
  output logic [INST_W-1:0]      o_if_id_inst,
  output logic [31:0]            o_fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t              state;
  logic [PC_W-1:0]     pc;
  logic [INST_W-1:0]   pend_inst;
  logic                pend_valid;

  // An IF/ID load can come from a live response or from the pending buffer
  // after a stall. A redirect in the same cycle always suppresses the load.
  logic                load_resp;
  logic                load_pend;
  logic                load;
  logic                capture_pend;
  logic [INST_W-1:0]   load_inst;
  logic [PC_W-1:0]     pc_inc;

  assign load_resp    = (state == WAIT) && imem.rvalid && !i_stall && !i_pcsrc;
  assign load_pend    = (state == HOLD) && pend_valid  && !i_stall && !i_pcsrc;
  assign load         = load_resp || load_pend;
  assign capture_pend = (state == WAIT) && imem.rvalid &&  i_stall && !i_pcsrc;
  assign load_inst    = load_resp ? imem.rdata : pend_inst;
  assign pc_inc       = pc + PC_W'(4);   // wraps modulo 2^PC_W

  // The request stays asserted while waiting in REQ. The address is the live
  // PC, so a redirect can retarget a request that has not been accepted yet.
  assign imem.valid = (state == REQ);
  assign imem.addr  = pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      pend_inst     <= '0;
      pend_valid    <= 1'b0;
      o_if_id_valid <= 1'b0;
      o_if_id_pc    <= '0;
      o_if_id_inst  <= '0;
    end else begin
      // IF/ID register. A flush takes priority, then a load, then a stall
      // hold. With none of these, a bubble is inserted.
      if (i_pcsrc) begin
        o_if_id_valid <= 1'b0;
      end else if (load) begin
        o_if_id_valid <= 1'b1;
        o_if_id_pc    <= pc;
        o_if_id_inst  <= load_inst;
      end else if (!i_stall) begin
        o_if_id_valid <= 1'b0;
      end

      // The PC advances only when an instruction is delivered.
      if (i_pcsrc) begin
        pc <= i_branch_target;
      end else if (load) begin
        pc <= pc_inc;
      end

      // Pending buffer: holds a response that arrived while stalled.
      if (i_pcsrc) begin
        pend_valid <= 1'b0;
      end else if (capture_pend) begin
        pend_valid <= 1'b1;
        pend_inst  <= imem.rdata;
      end else if (load_pend) begin
        pend_valid <= 1'b0;
      end

      case (state)
        IDLE: state <= REQ;
        REQ: begin
          // If a redirect arrives as the old address is accepted, that
          // request's response is stale and must be drained.
          if (imem.ready) state <= i_pcsrc ? DROP : WAIT;
        end
        WAIT: begin
          if (i_pcsrc)          state <= imem.rvalid ? REQ : DROP;
          else if (imem.rvalid) state <= i_stall ? HOLD : REQ;
        end
        HOLD: begin
          if (i_pcsrc || !i_stall) state <= REQ;
        end
        DROP: begin
          // The stale response is discarded whenever it arrives. If a new
          // redirect coincides with it, the drain is already complete, so
          // the FSM leaves DROP rather than wait for a response that will
          // never come.
          if (imem.rvalid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_cnt <= '0;
    end else if (load) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = fetch_cnt;
`else
  assign o_fetch_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
//  Module   : tb_inst_fetch
//  Purpose  : Self-checking bench for inst_fetch. The stimulus pushes the
//             expected accepted addresses and IF/ID loads into queues.
//             Monitors pop and compare them whenever the DUT shows an accept
//             or a fresh IF/ID entry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcsrc;
  logic        stall;
  logic [63:0] target;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  imem_if #(.PC_W(64), .INST_W(32)) imem ();

  inst_fetch #(
    .PC_W     (64),
    .INST_W   (32),
    .RESET_PC (64'h100)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pcsrc         (pcsrc),
    .i_branch_target (target),
    .i_stall         (stall),
    .imem            (imem),
    .o_if_id_valid   (if_id_valid),
    .o_if_id_pc      (if_id_pc),
    .o_if_id_inst    (if_id_inst),
    .o_fetch_cnt     (fetch_cnt)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [63:0] exp_addr_q [$];
  logic [95:0] exp_ifid_q [$];
  int          acc_cyc [$];
  logic        prev_stall = 1'b1;

`ifdef IF_PERF_CNT_EN
  localparam logic [31:0] CNT_AT5 = 32'd5;
  localparam logic [31:0] CNT_END = 32'd8;
`else
  localparam logic [31:0] CNT_AT5 = 32'd0;
  localparam logic [31:0] CNT_END = 32'd0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor. Sampling happens on the falling edge. Handshakes seen here
  // complete at the next rising edge. An IF/ID entry counts as fresh when it
  // is valid and the previous rising edge did not sample a stall.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_id_valid && !prev_stall) begin
        if (exp_ifid_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ifid_unexpected: got pc=%h inst=%h expected none", if_id_pc, if_id_inst);
        end else begin
          automatic logic [95:0] e = exp_ifid_q.pop_front();
          chk("ifid_pc",   if_id_pc,          e[95:32]);
          chk("ifid_inst", {32'd0, if_id_inst}, {32'd0, e[31:0]});
        end
      end
      if (imem.valid && imem.ready) begin
        acc_cyc.push_back(cyc);
        if (exp_addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL addr_unexpected: got %h expected none", imem.addr);
        end else begin
          automatic logic [63:0] a = exp_addr_q.pop_front();
          chk("accept_addr", imem.addr, a);
        end
      end
    end
    prev_stall = stall;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [63:0] a);
    int n = 0;
    exp_addr_q.push_back(a);
    imem.ready = 1'b1;
    while (!imem.valid && n < 20) begin
      tick();
      n++;
    end
    if (!imem.valid) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no request expected addr %h", a);
    end
    tick();
    imem.ready = 1'b0;
  endtask

  task automatic respond(input int k, input logic [31:0] d);
    repeat (k - 1) tick();
    imem.rvalid = 1'b1;
    imem.rdata  = d;
    tick();
    imem.rvalid = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] a, input logic [31:0] d, input int k);
    exp_ifid_q.push_back({a, d});
    accept(a);
    respond(k, d);
  endtask

  initial begin
    rst_n       = 1'b0;
    pcsrc       = 1'b0;
    stall       = 1'b0;
    target      = '0;
    imem.ready  = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_imem_valid", {63'd0, imem.valid}, 64'd0);
    chk("rst_imem_addr",  imem.addr, 64'h100);
    chk("rst_ifid_valid", {63'd0, if_id_valid}, 64'd0);
    chk("rst_ifid_pc",    if_id_pc, 64'd0);
    chk("rst_ifid_inst",  {32'd0, if_id_inst}, 64'd0);
    chk("rst_fetch_cnt",  {32'd0, fetch_cnt}, 64'd0);
    rst_n = 1'b1;

    // Back-to-back fetches, k=1: one accept every 2 cycles
    fetch(64'h100, 32'h0010_0093, 1);
    fetch(64'h104, 32'h0020_0113, 1);
    fetch(64'h108, 32'h0030_8193, 1);
    chk("accept_spacing_1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);
    chk("accept_spacing_2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd2);

    // Stall across the response: IF/ID holds, response parked, then released
    stall = 1'b1;
    accept(64'h10C);
    respond(1, 32'h0041_0213);
    chk("stall_ifid_valid", {63'd0, if_id_valid}, 64'd1);
    chk("stall_ifid_pc",    if_id_pc, 64'h108);
    chk("stall_ifid_inst",  {32'd0, if_id_inst}, {32'd0, 32'h0030_8193});
    chk("stall_no_request", {63'd0, imem.valid}, 64'd0);
    tick();
    tick();
    chk("stall_hold_pc",    if_id_pc, 64'h108);
    chk("stall_hold_req",   {63'd0, imem.valid}, 64'd0);
    stall = 1'b0;
    exp_ifid_q.push_back({64'h10C, 32'h0041_0213});
    tick();
    chk("release_next_addr", imem.addr, 64'h110);

    // Redirect in WAIT, stale response 2 cycles later
    accept(64'h110);
    pcsrc  = 1'b1;
    target = 64'h2000;
    tick();
    pcsrc  = 1'b0;
    chk("drop_ifid_valid_0", {63'd0, if_id_valid}, 64'd0);
    chk("drop_no_request",   {63'd0, imem.valid}, 64'd0);
    tick();
    chk("drop_ifid_valid_1", {63'd0, if_id_valid}, 64'd0);
    respond(1, 32'hBAD0_0BAD);
    chk("drop_ifid_valid_2", {63'd0, if_id_valid}, 64'd0);
    chk("drop_next_addr",    imem.addr, 64'h2000);
    fetch(64'h2000, 32'hDEAD_0001, 2);
    chk("fetch_cnt_5", {32'd0, fetch_cnt}, {32'd0, CNT_AT5});

    // Redirect in the same cycle as rvalid: no DROP state
    accept(64'h2004);
    imem.rvalid = 1'b1;
    imem.rdata  = 32'hBAD1_1BAD;
    pcsrc       = 1'b1;
    target      = 64'h3000;
    tick();
    imem.rvalid = 1'b0;
    pcsrc       = 1'b0;
    chk("same_ifid_valid", {63'd0, if_id_valid}, 64'd0);
    chk("same_req_valid",  {63'd0, imem.valid}, 64'd1);
    chk("same_req_addr",   imem.addr, 64'h3000);
    fetch(64'h3000, 32'h3000_0AAA, 1);

    // Redirect of an unaccepted request, then PC wrap-around
    pcsrc  = 1'b1;
    target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    pcsrc  = 1'b0;
    chk("retarget_addr", imem.addr, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFC_0001, 1);
    chk("wrap_addr", imem.addr, 64'h0);
    fetch(64'h0, 32'h0000_0001, 1);
    chk("fetch_cnt_end", {32'd0, fetch_cnt}, {32'd0, CNT_END});

    tick();
    tick();
    chk("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
    chk("ifid_q_empty", 64'(exp_ifid_q.size()), 64'd0);

    // Asynchronous reset mid-fetch
    accept(64'h4);
    rst_n = 1'b0;
    #1;
    chk("arst_imem_valid", {63'd0, imem.valid}, 64'd0);
    chk("arst_imem_addr",  imem.addr, 64'h100);
    chk("arst_ifid_valid", {63'd0, if_id_valid}, 64'd0);
    chk("arst_ifid_pc",    if_id_pc, 64'd0);
    chk("arst_fetch_cnt",  {32'd0, fetch_cnt}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
